// File: rtl/bin_to_bcd_serializer.sv
// bin_to_bcd_serializer
// Converts one unsigned binary word to packed BCD with a sequential
// double-dabble engine, then streams the digits MSD first, one per
// handshake, on a 4-bit bus.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds its data and valid
// stable until that transfer; ready may change freely.
module bin_to_bcd_serializer #(
    parameter int BIN_WIDTH  = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIN_WIDTH-1:0] bin_in,
    input  logic                 bin_valid,
    output logic                 bin_ready,
    output logic [3:0]           bcd_digit,
    output logic                 digit_valid,
    input  logic                 digit_ready,
    output logic                 digit_last,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t               r_state;
    logic [BIN_WIDTH-1:0] r_shift;
    logic [BCD_W-1:0]     r_bcd;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [3:0]           r_digit;
    logic                 r_digit_valid;
    logic                 r_digit_last;
    logic                 r_bin_ready;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic                 w_accept;

    assign w_accept    = bin_valid & r_bin_ready;
    assign bin_ready   = r_bin_ready;
    assign bcd_digit   = r_digit;
    assign digit_valid = r_digit_valid;
    assign digit_last  = r_digit_last;
    assign busy        = (r_state != S_IDLE);
    assign state_dbg   = r_state;

    // Add-3 correction: every nibble >= 5 gets +3, all judged on pre-add values
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Main FSM. In EMIT the BCD register shifts left one nibble per loaded
    // digit, so the next digit to present is always the top nibble.
    // The first EMIT cycle only loads the output register (registered digits).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bcd         <= '0;
            r_bit_cnt     <= '0;
            r_idx         <= '0;
            r_digit       <= 4'd0;
            r_digit_valid <= 1'b0;
            r_digit_last  <= 1'b0;
            r_bin_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift     <= bin_in;
                        r_bcd       <= '0;
                        r_bit_cnt   <= '0;
                        r_bin_ready <= 1'b0;
                        r_state     <= S_CONVERT;
                    end else begin
                        r_bin_ready <= 1'b1;
                    end
                end
                S_CONVERT: begin
                    r_bcd     <= {w_bcd_adj[BCD_W-2:0], r_shift[BIN_WIDTH-1]};
                    r_shift   <= {r_shift[BIN_WIDTH-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        r_idx   <= TOP_IDX;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!r_digit_valid) begin
                        r_digit       <= r_bcd[BCD_W-1 -: 4];
                        r_bcd         <= r_bcd << 4;
                        r_digit_valid <= 1'b1;
                        r_digit_last  <= (r_idx == IDX_ZERO);
                    end else if (digit_ready) begin
                        if (r_idx == IDX_ZERO) begin
                            r_digit       <= 4'd0;
                            r_digit_valid <= 1'b0;
                            r_digit_last  <= 1'b0;
                            r_bit_cnt     <= '0;
                            r_bin_ready   <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            r_idx        <= r_idx - 1'b1;
                            r_digit      <= r_bcd[BCD_W-1 -: 4];
                            r_bcd        <= r_bcd << 4;
                            r_digit_last <= (r_idx == IDX_ONE);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
